// File: rtl/seq_pkg.sv
// seq_pkg: state encoding and reference opcodes shared by instr_sequencer and its bench.
package seq_pkg;
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;
    localparam logic [15:0] OP_NOP  = 16'h7200;
    localparam logic [15:0] OP_HALT = 16'h73FF;
endpackage

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer with registered outputs.
// Optional SEQ_RETIRE_CNT_EN adds the retired_cnt output.
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int A_BITS = 10,
    parameter int I_BITS = 16
) (
    input  logic              clk,
    input  logic              rst,
    output logic              imem_req,
    output logic [A_BITS-1:0] imem_addr,
    input  logic [I_BITS-1:0] imem_rdata,
    input  logic              imem_ack,
    output logic [I_BITS-1:0] ir,
    input  logic              dec_mem_read,
    input  logic              dec_mem_write,
    input  logic              dec_reg_write,
    input  logic              dec_alu_en,
    input  logic              dec_halt,
    input  logic              jmp_taken,
    input  logic [A_BITS-1:0] jmp_target,
    output logic              dmem_req,
    output logic              dmem_we,
    input  logic              dmem_ack,
    output logic              alu_go,
    output logic              reg_we,
    output logic [A_BITS-1:0] pc,
    output logic              halted
`ifdef SEQ_RETIRE_CNT_EN
    ,
    output logic [31:0]       retired_cnt
`endif
);
    logic [2:0] state, next;
    logic fetch_done, mem_done;
    logic imem_req_d, dmem_req_d, dmem_we_d, alu_go_d, reg_we_d, halted_d;

    // Acks only count while the matching request is actually up.
    assign fetch_done = imem_req && imem_ack;
    assign mem_done   = dmem_req && dmem_ack;
    assign imem_addr  = pc;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_FETCH;
            imem_req <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            alu_go   <= 1'b0;
            reg_we   <= 1'b0;
            halted   <= 1'b0;
        end else begin
            state    <= next;
            imem_req <= imem_req_d;
            dmem_req <= dmem_req_d;
            dmem_we  <= dmem_we_d;
            alu_go   <= alu_go_d;
            reg_we   <= reg_we_d;
            halted   <= halted_d;
        end
    end

    always_comb begin
        next = state;
        case (state)
            S_FETCH:  next = fetch_done ? S_DECODE : S_FETCH;
            S_DECODE: next = dec_halt ? S_HALT : S_EXEC;
            S_EXEC:   next = (dec_mem_read || dec_mem_write) ? S_MEM : dec_reg_write ? S_WB : S_FETCH;
            S_MEM:    next = !mem_done ? S_MEM : dec_reg_write ? S_WB : S_FETCH;
            S_WB:     next = S_FETCH;
            S_HALT:   next = S_HALT;
            default:  next = S_FETCH;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they belong to.
    always_comb begin
        imem_req_d = next == S_FETCH;
        dmem_req_d = next == S_MEM;
        dmem_we_d  = (next == S_MEM) && dec_mem_write;
        alu_go_d   = (next == S_EXEC) && dec_alu_en;
        reg_we_d   = next == S_WB;
        halted_d   = next == S_HALT;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pc <= '0;
            ir <= '0;
        end else begin
            pc <= (state == S_EXEC) ? (jmp_taken ? jmp_target : pc + A_BITS'(1)) : pc;
            ir <= (state == S_FETCH && fetch_done) ? imem_rdata : ir;
        end
    end

`ifdef SEQ_RETIRE_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            retired_cnt <= '0;
        else if (next == S_FETCH && (state == S_EXEC || state == S_MEM || state == S_WB))
            retired_cnt <= retired_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_instr_sequencer.sv
// tb_instr_sequencer: directed cycle-by-cycle checks of instr_sequencer with a tiny stub decoder.
module tb_instr_sequencer;
    import seq_pkg::*;
    localparam int A_BITS = 10;
    localparam int I_BITS = 16;
    localparam logic [15:0] OP_ADD   = 16'h1000;
    localparam logic [15:0] OP_LOAD  = 16'h2000;
    localparam logic [15:0] OP_STORE = 16'h3000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic imem_req, imem_ack, dec_mem_read, dec_mem_write, dec_reg_write, dec_alu_en, dec_halt;
    logic jmp_taken, dmem_req, dmem_we, dmem_ack, alu_go, reg_we, halted;
    logic [A_BITS-1:0] imem_addr, jmp_target, pc;
    logic [I_BITS-1:0] imem_rdata, ir;
    logic [15:0] prog [0:1023];
    logic dack_force = 1'b0;
    logic acc;
    int dwait = 0;
    int dcnt = 0;
    int viol = 0;
    int errors = 0;
    int checks = 0;
`ifdef SEQ_RETIRE_CNT_EN
    logic [31:0] retired_cnt;
`endif

    instr_sequencer #(.A_BITS(A_BITS), .I_BITS(I_BITS)) dut (
        .clk(clk), .rst(rst),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
        .ir(ir),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write), .dec_reg_write(dec_reg_write),
        .dec_alu_en(dec_alu_en), .dec_halt(dec_halt),
        .jmp_taken(jmp_taken), .jmp_target(jmp_target),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
        .alu_go(alu_go), .reg_we(reg_we), .pc(pc), .halted(halted)
`ifdef SEQ_RETIRE_CNT_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    // Zero-wait instruction memory and a stub decoder keyed on the top nibble of ir.
    assign imem_rdata    = prog[imem_addr];
    assign imem_ack      = imem_req;
    assign dec_mem_read  = ir[15:12] == 4'h2 || ir[15:12] == 4'h3;
    assign dec_mem_write = ir[15:12] == 4'h3;
    assign dec_reg_write = ir[15:12] == 4'h1 || ir[15:12] == 4'h2;
    assign dec_alu_en    = ir[15:12] == 4'h1 || ir[15:12] == 4'h2 || ir[15:12] == 4'h3;
    assign dec_halt      = ir == OP_HALT;
    assign jmp_taken     = ir[15:12] == 4'h4;
    assign jmp_target    = ir[A_BITS-1:0];
    assign dmem_ack      = dack_force || (dmem_req && dcnt == dwait);

    always @(posedge clk) dcnt <= (dmem_req && !dmem_ack) ? dcnt + 1 : 0;

    always @(negedge clk)
        if ((reg_we && alu_go) || (imem_req && dmem_req)) viol <= viol + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        foreach (prog[i]) prog[i] = OP_NOP;
        prog[0] = OP_ADD;
        prog[1] = OP_LOAD;
        prog[2] = OP_STORE;
        prog[3] = 16'h4155;
        prog[10'h155] = 16'h43FF;
        tick(2);
        check("rst_pc", pc, 0);
        check("rst_ir", ir, 0);
        check("rst_imem_req", imem_req, 0);
        check("rst_dmem", {dmem_req, dmem_we}, 0);
        check("rst_pulses", {alu_go, reg_we}, 0);
        check("rst_halted", halted, 0);
        rst = 1'b0;
        tick;
        check("add_f_req", imem_req, 1);
        check("add_f_addr", imem_addr, 0);
        tick;
        check("add_d_ir", ir, OP_ADD);
        check("add_d_req", imem_req, 0);
        tick;
        check("add_e_alu", alu_go, 1);
        check("add_e_we", reg_we, 0);
        tick;
        check("add_w_we", reg_we, 1);
        check("add_w_alu", alu_go, 0);
        check("add_w_pc", pc, 1);
        tick;
        check("add_next_req", imem_req, 1);
        check("add_next_addr", imem_addr, 1);
        check("add_next_we", reg_we, 0);
        dwait = 2;
        tick(2);
        check("ld_e_alu", alu_go, 1);
        tick;
        check("ld_m0", {dmem_req, dmem_we}, 2'b10);
        tick;
        check("ld_m1", {dmem_req, dmem_we}, 2'b10);
        tick;
        check("ld_m2", {dmem_req, dmem_we}, 2'b10);
        check("ld_m2_we", reg_we, 0);
        tick;
        check("ld_wb_we", reg_we, 1);
        check("ld_wb_dreq", dmem_req, 0);
        tick;
        check("ld_next_req", imem_req, 1);
        check("ld_next_addr", imem_addr, 2);
        check("ld_next_we", reg_we, 0);
        dwait = 0;
        acc = 1'b0;
        repeat (3) begin
            tick;
            acc |= reg_we;
        end
        check("st_m", {dmem_req, dmem_we}, 2'b11);
        tick;
        acc |= reg_we;
        check("st_no_we", acc, 0);
        check("st_next_req", imem_req, 1);
        check("st_next_addr", imem_addr, 3);
        tick(3);
        check("jmp_addr", imem_addr, 10'h155);
        check("jmp_req", imem_req, 1);
        tick(3);
        check("jmp2_addr", imem_addr, 10'h3FF);
        tick(3);
        check("wrap_addr", imem_addr, 0);
        check("wrap_req", imem_req, 1);

        rst = 1'b1;
        #1;
        prog[0] = 16'h4007;
        prog[7] = OP_HALT;
        tick(2);
        rst = 1'b0;
        tick;
        tick(3);
        check("halt_f_addr", imem_addr, 7);
        tick;
        check("halt_d_halted", halted, 0);
        tick;
        check("halt_halted", halted, 1);
        check("halt_pc", pc, 7);
        check("halt_req", imem_req, 0);
        acc = 1'b0;
        repeat (20) begin
            tick;
            acc |= imem_req | dmem_req | reg_we | alu_go | (pc != 10'd7) | !halted;
        end
        check("halt_quiet", acc, 0);
        rst = 1'b1;
        #1;
        check("halt_rst_async", halted, 0);

        prog[0] = OP_LOAD;
        dwait = 100;
        tick(2);
        rst = 1'b0;
        tick(4);
        check("rstm_m0", dmem_req, 1);
        tick;
        check("rstm_m1", dmem_req, 1);
        rst = 1'b1;
        #1;
        check("rstm_dreq_async", {dmem_req, dmem_we}, 0);
        for (int i = 0; i < 4; i++) prog[i] = OP_NOP;
        dwait = 0;
        tick(2);
        rst = 1'b0;
        tick;
        dack_force = 1'b1;
        check("rstm_restart_req", imem_req, 1);
        check("rstm_restart_addr", imem_addr, 0);
`ifdef SEQ_RETIRE_CNT_EN
        check("ret_after_rst", retired_cnt, 0);
`endif
        tick;
        dack_force = 1'b0;
        check("rstm_late_ack_dreq", dmem_req, 0);
        check("rstm_ir", ir, OP_NOP);
        acc = reg_we;
        repeat (8) begin
            tick;
            acc |= reg_we | dmem_req;
        end
        check("rstm_no_we", acc, 0);
        check("nop3_addr", imem_addr, 3);
        check("nop3_req", imem_req, 1);
`ifdef SEQ_RETIRE_CNT_EN
        check("ret_three_nops", retired_cnt, 3);
`endif
        check("invariants", viol, 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
